// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller (forwarding enabled by PIPE_HAZARD_FWD_EN).
// Latency: none, types and constants only.
// Backpressure: none.
package pipe_pkg;

  // MDU sequencing states: normal flow, or EXE held by a multi-cycle op.
  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } mdu_state_t;

  // Operand source selects presented to the ID-stage operand muxes.
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXE   = 2'd1;
  localparam logic [1:0] FWD_MEM   = 2'd2;
  localparam logic [1:0] FWD_MEMLD = 2'd3;

  // Enable/flush bundle for the pipeline registers.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_exe_en;
    logic if_id_flush;
    logic id_exe_flush;
    logic exe_mem_flush;
  } pipe_ctrl_t;

  // Free-running pipeline: everything advances, nothing is squashed.
  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_en:         1'b1,
    if_id_en:      1'b1,
    id_exe_en:     1'b1,
    if_id_flush:   1'b0,
    id_exe_flush:  1'b0,
    exe_mem_flush: 1'b0
  };

endpackage

// File: rtl/pipe_fwd_unit.sv
// Per-operand RAW compare against EXE/MEM producing a forward select and a stall request (PIPE_HAZARD_FWD_EN selects forwarding).
// Latency: purely combinational, valid in the same cycle as the ID operands.
// Backpressure: none; the stall request is consumed by the hazard controller.
module pipe_fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] id_r,
  input  logic       id_use,
  input  logic       exe_wreg,
  input  logic       exe_m2reg,
  input  logic [4:0] exe_rn,
  input  logic       mem_wreg,
  input  logic       mem_m2reg,
  input  logic [4:0] mem_rn,
  output logic [1:0] fwd,
  output logic       stall
);

  logic exe_hit;
  logic mem_hit;

  // Register 0 is hard-wired, so a producer targeting it never creates a dependency.
  assign exe_hit = exe_wreg && (exe_rn != 5'd0) && (exe_rn == id_r);
  assign mem_hit = mem_wreg && (mem_rn != 5'd0) && (mem_rn == id_r);

`ifdef PIPE_HAZARD_FWD_EN
  // Youngest producer wins; a load still in EXE has no data yet and falls through to MEM.
  always_comb begin
    fwd = FWD_RF;
    if (exe_hit && !exe_m2reg) begin
      fwd = FWD_EXE;
    end else if (mem_hit) begin
      fwd = mem_m2reg ? FWD_MEMLD : FWD_MEM;
    end
  end

  // Only a load in EXE cannot be bypassed; it is forwarded from MEM one cycle later.
  assign stall = id_use && exe_hit && exe_m2reg;
`else
  logic unused_m2reg;

  // Without bypass paths, every pending producer must reach the register file first.
  assign fwd          = FWD_RF;
  assign stall        = id_use && (exe_hit || mem_hit);
  assign unused_m2reg = exe_m2reg ^ mem_m2reg;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: pipeline enables/flushes, forward selects, MDU occupancy (forwarding enabled by PIPE_HAZARD_FWD_EN).
// Latency: controls combinational from inputs and registered MDU state; stall_cnt updates one edge later.
// Backpressure: stalls IF/ID for load-use/RAW, freezes IF..EXE for MDU_LAT-1 cycles, squashes on taken branch.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             exe_wreg,
  input  logic             exe_m2reg,
  input  logic [4:0]       exe_rn,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [4:0]       mem_rn,
  input  logic             exe_branch,
  input  logic             exe_mdu,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_exe_en,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             exe_mem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  // cnt holds the number of MDU_WAIT cycles still to run, including the current one.
  // The entry cycle is frozen combinationally, so MDU_WAIT covers the remaining MDU_LAT-2.
  localparam int             CW       = $clog2(MDU_LAT);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(MDU_LAT - 2);
  localparam logic [CW-1:0]  CNT_LAST = CW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mdu_state_t    state;
  mdu_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          rel_q;
  logic          rel_nxt;
  logic [1:0]    fwd_a_raw;
  logic [1:0]    fwd_b_raw;
  logic          stall_a;
  logic          stall_b;
  logic          raw_stall;
  logic          mdu_freeze;
  pipe_ctrl_t    ctrl;

  pipe_fwd_unit u_fwd_a (
    .id_r      (id_rs),
    .id_use    (id_use_rs),
    .exe_wreg  (exe_wreg),
    .exe_m2reg (exe_m2reg),
    .exe_rn    (exe_rn),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rn    (mem_rn),
    .fwd       (fwd_a_raw),
    .stall     (stall_a)
  );

  pipe_fwd_unit u_fwd_b (
    .id_r      (id_rt),
    .id_use    (id_use_rt),
    .exe_wreg  (exe_wreg),
    .exe_m2reg (exe_m2reg),
    .exe_rn    (exe_rn),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rn    (mem_rn),
    .fwd       (fwd_b_raw),
    .stall     (stall_b)
  );

  assign raw_stall = stall_a | stall_b;

  // MDU sequencing registers: state, wait countdown and the one-cycle release marker.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= RUN;
      cnt   <= '0;
      rel_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rel_q <= rel_nxt;
    end
  end

  // Next MDU state and pipeline controls; priority is reset, MDU freeze, branch, RAW stall.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rel_nxt    = 1'b0;
    mdu_freeze = 1'b0;
    ctrl       = CTRL_RUN;

    case (state)
      RUN: begin
        // rel_q marks the cycle the finished MDU op leaves EXE; its exe_mdu must not re-arm.
        if (exe_mdu && !rel_q) begin
          mdu_freeze = 1'b1;
          if (CNT_LOAD == '0) begin
            rel_nxt = 1'b1;
          end else begin
            state_nxt = MDU_WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      MDU_WAIT: begin
        mdu_freeze = 1'b1;
        cnt_nxt    = cnt - CNT_LAST;
        if (cnt == CNT_LAST) begin
          state_nxt = RUN;
          rel_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase

    if (clr) begin
      ctrl = CTRL_RUN;
    end else if (mdu_freeze) begin
      // Hold everything up to EXE and feed bubbles into MEM while the MDU works.
      ctrl.pc_en         = 1'b0;
      ctrl.if_id_en      = 1'b0;
      ctrl.id_exe_en     = 1'b0;
      ctrl.exe_mem_flush = 1'b1;
    end else if (exe_branch) begin
      // The ops in IF/ID and ID are on the wrong path; any stall they raise is moot.
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_exe_flush = 1'b1;
    end else if (raw_stall) begin
      // Hold the dependent op in ID and send a bubble into EXE.
      ctrl.pc_en        = 1'b0;
      ctrl.if_id_en     = 1'b0;
      ctrl.id_exe_flush = 1'b1;
    end
  end

  assign pc_en         = ctrl.pc_en;
  assign if_id_en      = ctrl.if_id_en;
  assign id_exe_en     = ctrl.id_exe_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_exe_flush  = ctrl.id_exe_flush;
  assign exe_mem_flush = ctrl.exe_mem_flush;
  assign fwd_a         = clr ? FWD_RF : fwd_a_raw;
  assign fwd_b         = clr ? FWD_RF : fwd_b_raw;

  // Count cycles the PC is held, sticking at all-ones.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cnt <= '0;
    end else if (!ctrl.pc_en && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl against a cycle-level behavioural model.
// Latency: checks land 1 time unit after each negedge input update.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;
  localparam int SAT     = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       pc_en;
    logic       if_id_en;
    logic       id_exe_en;
    logic       if_id_flush;
    logic       id_exe_flush;
    logic       exe_mem_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
  } outs_t;

  localparam outs_t IDLE_OUT = {6'b111000, 2'b00, 2'b00};

  logic             clk;
  logic             clr;
  logic [4:0]       id_rs, id_rt;
  logic             id_use_rs, id_use_rt;
  logic             exe_wreg, exe_m2reg;
  logic [4:0]       exe_rn;
  logic             mem_wreg, mem_m2reg;
  logic [4:0]       mem_rn;
  logic             exe_branch, exe_mdu;
  logic             pc_en, if_id_en, id_exe_en;
  logic             if_id_flush, id_exe_flush, exe_mem_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // Model state: remaining frozen MDU cycles after the entry cycle, release-cycle flag, stall count.
  int m_left   = 0;
  bit m_rel    = 0;
  int m_stalls = 0;

  pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .clr           (clr),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_use_rs     (id_use_rs),
    .id_use_rt     (id_use_rt),
    .exe_wreg      (exe_wreg),
    .exe_m2reg     (exe_m2reg),
    .exe_rn        (exe_rn),
    .mem_wreg      (mem_wreg),
    .mem_m2reg     (mem_m2reg),
    .mem_rn        (mem_rn),
    .exe_branch    (exe_branch),
    .exe_mdu       (exe_mdu),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_exe_en     (id_exe_en),
    .if_id_flush   (if_id_flush),
    .id_exe_flush  (id_exe_flush),
    .exe_mem_flush (exe_mem_flush),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t observe();
    return {pc_en, if_id_en, id_exe_en, if_id_flush, id_exe_flush, exe_mem_flush, fwd_a, fwd_b};
  endfunction

  // Operand source for register r given what EXE and MEM are producing.
  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    logic [1:0] f;
    f = 2'd0;
`ifdef PIPE_HAZARD_FWD_EN
    if (exe_wreg && !exe_m2reg && exe_rn == r)   f = 2'd1;
    else if (mem_wreg && mem_rn == r)            f = mem_m2reg ? 2'd3 : 2'd2;
`endif
    if (r == 5'd0) f = 2'd0;
    return f;
  endfunction

  // Does a read of r by the ID op have to wait this cycle?
  function automatic bit m_dep(input logic [4:0] r, input logic use_r);
`ifdef PIPE_HAZARD_FWD_EN
    return use_r && r != 5'd0 && exe_wreg && exe_m2reg && exe_rn == r;
`else
    return use_r && r != 5'd0 && ((exe_wreg && exe_rn == r) || (mem_wreg && mem_rn == r));
`endif
  endfunction

  function automatic outs_t model_exp();
    outs_t e;
    e = IDLE_OUT;
    if (clr) return e;
    e.fwd_a = m_fwd(id_rs);
    e.fwd_b = m_fwd(id_rt);
    if (m_left > 0 || (exe_mdu && !m_rel)) begin
      e.pc_en = 1'b0; e.if_id_en = 1'b0; e.id_exe_en = 1'b0; e.exe_mem_flush = 1'b1;
    end else if (exe_branch) begin
      e.if_id_flush = 1'b1; e.id_exe_flush = 1'b1;
    end else if (m_dep(id_rs, id_use_rs) || m_dep(id_rt, id_use_rt)) begin
      e.pc_en = 1'b0; e.if_id_en = 1'b0; e.id_exe_flush = 1'b1;
    end
    return e;
  endfunction

  task automatic model_reset();
    m_left = 0; m_rel = 0; m_stalls = 0;
  endtask

  // Advance one clock: update the model with the inputs seen at this edge, return at negedge.
  task automatic step();
    outs_t e;
    @(posedge clk);
    e = model_exp();
    if (clr) begin
      model_reset();
    end else begin
      if (!e.pc_en && m_stalls < SAT) m_stalls++;
      if (m_left > 0) begin
        m_left--;
        m_rel = (m_left == 0);
      end else if (exe_mdu && !m_rel) begin
        m_left = MDU_LAT - 2;
        m_rel  = (m_left == 0);
      end else begin
        m_rel = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    exe_wreg = 0; exe_m2reg = 0; exe_rn = 0;
    mem_wreg = 0; mem_m2reg = 0; mem_rn = 0;
    exe_branch = 0; exe_mdu = 0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    model_reset();
    idle();
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    outs_t o;
    clr = 1'b1;
    idle();
    exe_mdu = 1; exe_branch = 1; id_rt = 5; id_use_rt = 1;
    exe_wreg = 1; exe_m2reg = 1; exe_rn = 5; id_rs = 5; mem_wreg = 1; mem_rn = 5;
    #1;
    o = observe();
    checks++;
    if (o !== IDLE_OUT) begin errors++; $display("FAIL reset_outs: got %b want %b", o, IDLE_OUT); end
    checks++;
    if (stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    step();
    step();
    #1;
    o = observe();
    checks++;
    if (o !== IDLE_OUT || stall_cnt !== '0) begin
      errors++; $display("FAIL reset_hold: got %b cnt=%0d want %b cnt=0", o, stall_cnt, IDLE_OUT);
    end
    clr = 1'b0;
    idle();
    #1;
    o = observe();
    checks++;
    if (o !== IDLE_OUT) begin errors++; $display("FAIL reset_release: got %b want %b", o, IDLE_OUT); end
    step();
  endtask

  task automatic test_forward();
    outs_t o, e;
    do_reset();
    // Writes to register 0 never create a dependency.
    id_rs = 0; id_use_rs = 1; exe_rn = 0; exe_wreg = 1; exe_m2reg = 1;
    #1;
    checks++;
    if (pc_en !== 1'b1 || fwd_a !== 2'd0) begin
      errors++; $display("FAIL r0_ignored: pc_en=%b fwd_a=%0d want 1/0", pc_en, fwd_a);
    end
    step();
`ifdef PIPE_HAZARD_FWD_EN
    idle();
    id_rs = 3; id_use_rs = 1; exe_rn = 3; exe_wreg = 1;
    #1;
    checks++;
    if (fwd_a !== 2'd1 || pc_en !== 1'b1) begin
      errors++; $display("FAIL fwd_exe: fwd_a=%0d pc_en=%b want 1/1", fwd_a, pc_en);
    end
    step();
    exe_wreg = 0; exe_rn = 0; mem_wreg = 1; mem_rn = 3;
    #1;
    checks++;
    if (fwd_a !== 2'd2) begin errors++; $display("FAIL fwd_mem: fwd_a=%0d want 2", fwd_a); end
    step();
`else
    idle();
    id_rs = 7; id_use_rs = 1; exe_rn = 7; exe_wreg = 1;
    #1;
    o = observe(); e = model_exp();
    checks++;
    if (o !== e || pc_en !== 1'b0 || fwd_a !== 2'd0) begin
      errors++; $display("FAIL raw_exe_stall: got %b want %b", o, e);
    end
    step();
    exe_wreg = 0; exe_rn = 0; mem_wreg = 1; mem_rn = 7;
    #1;
    o = observe(); e = model_exp();
    checks++;
    if (o !== e || pc_en !== 1'b0 || fwd_a !== 2'd0) begin
      errors++; $display("FAIL raw_mem_stall: got %b want %b", o, e);
    end
    step();
    mem_wreg = 0; mem_rn = 0;
    #1;
    checks++;
    if (pc_en !== 1'b1 || stall_cnt !== 4'd2) begin
      errors++; $display("FAIL raw_two_bubbles: pc_en=%b cnt=%0d want 1/2", pc_en, stall_cnt);
    end
    step();
`endif
  endtask

  task automatic test_load_use();
    outs_t o, e;
    do_reset();
    id_rt = 5; id_use_rt = 1; exe_rn = 5; exe_wreg = 1; exe_m2reg = 1;
    #1;
    o = observe(); e = model_exp();
    checks++;
    if (o !== e || pc_en !== 1'b0 || id_exe_flush !== 1'b1 || id_exe_en !== 1'b1) begin
      errors++; $display("FAIL load_use_stall: got %b want %b", o, e);
    end
    step();
    exe_wreg = 0; exe_m2reg = 0; exe_rn = 0; mem_wreg = 1; mem_m2reg = 1; mem_rn = 5;
    #1;
    o = observe(); e = model_exp();
    checks++;
    if (o !== e || stall_cnt !== 4'd1) begin
      errors++; $display("FAIL load_use_after: got %b cnt=%0d want %b cnt=1", o, stall_cnt, e);
    end
`ifdef PIPE_HAZARD_FWD_EN
    checks++;
    if (fwd_b !== 2'd3 || pc_en !== 1'b1) begin
      errors++; $display("FAIL fwd_memld: fwd_b=%0d pc_en=%b want 3/1", fwd_b, pc_en);
    end
`endif
    step();
  endtask

  task automatic test_branch();
    do_reset();
    exe_branch = 1; id_rt = 5; id_use_rt = 1; exe_rn = 5; exe_wreg = 1; exe_m2reg = 1;
    #1;
    checks++;
    if (if_id_flush !== 1'b1 || id_exe_flush !== 1'b1 || pc_en !== 1'b1 || if_id_en !== 1'b1) begin
      errors++; $display("FAIL branch_flush: ifid_fl=%b idexe_fl=%b pc_en=%b want 1/1/1",
                         if_id_flush, id_exe_flush, pc_en);
    end
    step();
    idle();
    #1;
    checks++;
    if (stall_cnt !== 4'd0 || if_id_flush !== 1'b0) begin
      errors++; $display("FAIL branch_no_stall: cnt=%0d ifid_fl=%b want 0/0", stall_cnt, if_id_flush);
    end
    step();
  endtask

  task automatic test_mdu();
    outs_t o, e;
    int frozen;
    do_reset();
    frozen = 0;
    exe_mdu = 1;
    for (int i = 0; i < MDU_LAT; i++) begin
      #1;
      o = observe(); e = model_exp();
      checks++;
      if (o !== e) begin errors++; $display("FAIL mdu_cycle%0d: got %b want %b", i, o, e); end
      if (!pc_en && !id_exe_en && exe_mem_flush) frozen++;
      step();
    end
    exe_mdu = 0;
    #1;
    checks++;
    if (frozen != MDU_LAT - 1 || stall_cnt !== 4'(MDU_LAT - 1)) begin
      errors++; $display("FAIL mdu_len: frozen=%0d cnt=%0d want %0d/%0d",
                         frozen, stall_cnt, MDU_LAT - 1, MDU_LAT - 1);
    end
    step();
  endtask

  task automatic test_mdu_reset();
    do_reset();
    exe_mdu = 1;
    step();
    step();
    // Now in the second MDU_WAIT cycle.
    clr = 1'b1;
    model_reset();
    #1;
    checks++;
    if (pc_en !== 1'b1 || if_id_en !== 1'b1 || id_exe_en !== 1'b1 || exe_mem_flush !== 1'b0 ||
        stall_cnt !== '0) begin
      errors++; $display("FAIL mdu_clr: en=%b%b%b emf=%b cnt=%0d want 111/0/0",
                         pc_en, if_id_en, id_exe_en, exe_mem_flush, stall_cnt);
    end
    step();
    clr = 1'b0;
    exe_mdu = 0;
    #1;
    checks++;
    if (pc_en !== 1'b1 || exe_mem_flush !== 1'b0) begin
      errors++; $display("FAIL mdu_clr_run: pc_en=%b emf=%b want 1/0", pc_en, exe_mem_flush);
    end
    step();
  endtask

  task automatic test_saturate();
    do_reset();
    id_rt = 9; id_use_rt = 1; exe_rn = 9; exe_wreg = 1; exe_m2reg = 1;
    for (int i = 0; i < SAT + 4; i++) step();
    #1;
    checks++;
    if (stall_cnt !== 4'(SAT) || 32'(stall_cnt) != m_stalls) begin
      errors++; $display("FAIL stall_saturate: cnt=%0d want %0d", stall_cnt, SAT);
    end
    step();
  endtask

  task automatic test_random();
    outs_t o, e;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      clr        = ($urandom_range(0, 63) == 0);
      id_rs      = 5'($urandom_range(0, 7));
      id_rt      = 5'($urandom_range(0, 7));
      id_use_rs  = 1'($urandom_range(0, 1));
      id_use_rt  = 1'($urandom_range(0, 1));
      exe_wreg   = 1'($urandom_range(0, 1));
      exe_m2reg  = 1'($urandom_range(0, 1));
      exe_rn     = 5'($urandom_range(0, 7));
      mem_wreg   = 1'($urandom_range(0, 1));
      mem_m2reg  = 1'($urandom_range(0, 1));
      mem_rn     = 5'($urandom_range(0, 7));
      exe_branch = ($urandom_range(0, 7) == 0);
      exe_mdu    = ($urandom_range(0, 7) == 0);
      if (clr) model_reset();
      #1;
      o = observe(); e = model_exp();
      checks++;
      if (o !== e) begin errors++; $display("FAIL rand_outs[%0d]: got %b want %b", i, o, e); end
      checks++;
      if (32'(stall_cnt) != m_stalls) begin
        errors++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, stall_cnt, m_stalls);
      end
      step();
    end
    clr = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mdu();
    test_mdu_reset();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
